// File: rtl/serial_add_pkg.sv
// Shared types and default sizing for the serial-adder sequencer.
// FSM state encoding lives here so sub-blocks and benches agree on it.
package serial_add_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;
endpackage

// File: rtl/serial_add_seq_op_fifo.sv
// Operand-pair FIFO: stores {A,B} as one 2*WIDTH word, DEPTH entries.
// Pointers carry one extra wrap bit to tell full from empty.
module op_fifo
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [2*WIDTH-1:0] i_data,
   input  logic               i_pop,
   output logic [2*WIDTH-1:0] o_data,
   output logic               o_full,
   output logic               o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [2*WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]        r_wr;
   logic [AW:0]        r_rd;
   logic               w_full;
   logic               w_empty;
   logic               w_wen;

   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                    (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_wen   = i_push && !w_full;

   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_data  = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_wen) begin
         r_mem[r_wr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wen) begin
            r_wr <= r_wr + 1'b1;
         end
         if (i_pop && !w_empty) begin
            r_rd <= r_rd + 1'b1;
         end
      end
   end
endmodule

// File: rtl/serial_add_seq.sv
// Sequencer for an external bit-serial adder: queues operand pairs,
// drives load/shift strobes, and presents the adder's result.
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             pload,
   output logic             enable,
   output logic [WIDTH-1:0] adata,
   output logic [WIDTH-1:0] bdata,
   input  logic [WIDTH-1:0] pout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_pload;
   logic               r_enable;
   logic [WIDTH-1:0]   r_adata;
   logic [WIDTH-1:0]   r_bdata;
   logic               r_res_valid;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic [2*WIDTH-1:0] w_head;

   assign in_ready = !w_full;
   assign w_push   = in_valid && !w_full;
   assign w_pop    = (r_state == IDLE) && !w_empty;

   op_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  ({in_a, in_b}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign pload     = r_pload;
   assign enable    = r_enable;
   assign adata     = r_adata;
   assign bdata     = r_bdata;
   assign res_valid = r_res_valid;
   // pout settles on the final shift edge, so pass it through live
   assign res_data  = r_res_valid ? pout : '0;
   assign busy      = (r_state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_pload     <= 1'b0;
         r_enable    <= 1'b0;
         r_adata     <= '0;
         r_bdata     <= '0;
         r_res_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state <= LOAD;
                  r_pload <= 1'b1;
                  r_adata <= w_head[2*WIDTH-1:WIDTH];
                  r_bdata <= w_head[WIDTH-1:0];
               end
            end
            LOAD: begin
               r_state  <= SHIFT;
               r_pload  <= 1'b0;
               r_adata  <= '0;
               r_bdata  <= '0;
               r_enable <= 1'b1;
               r_cnt    <= '0;
            end
            SHIFT: begin
               if (r_cnt == LAST) begin
                  r_state     <= DONE;
                  r_enable    <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (res_ready) begin
                  r_state     <= IDLE;
                  r_res_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter WIDTH, 8, operand/result width in bits; the adder datapath it drives is WIDTH bits wide.
REQ-002 Parameter DEPTH, 2, operand-pair FIFO entries; power of two, at least 2.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous, active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  FIFO can accept; equals not-full.
REQ-008 in_a  in  WIDTH  operand A.
REQ-009 in_b  in  WIDTH  operand B.
REQ-010 pload  out  1  load strobe to the serial adder.
REQ-011 enable  out  1  shift strobe to the serial adder.
REQ-012 adata  out  WIDTH  operand A to the adder, valid while pload=1, else 0.
REQ-013 bdata  out  WIDTH  operand B to the adder, valid while pload=1, else 0.
REQ-014 pout  in  WIDTH  parallel result from the adder.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts result.
REQ-017 res_data  out  WIDTH  result, (A+B) mod 2^WIDTH.
REQ-018 busy  out  1  FSM not in IDLE.

Function
REQ-019 Push SHALL occur on an edge with in_valid & in_ready; pop SHALL occur on the IDLE->LOAD edge; a push and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-020 in_ready SHALL be 0 when occupancy = DEPTH; FIFO pointers SHALL wrap modulo DEPTH; in_a/in_b offered while full SHALL be ignored.
REQ-021 FSM states SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-022 IDLE: transition to LOAD when the FIFO is non-empty; otherwise stay.
REQ-023 LOAD: exactly one cycle; pload=1, enable=0, adata/bdata = FIFO head; transition to SHIFT.
REQ-024 SHIFT: enable=1, pload=0 for exactly WIDTH consecutive cycles, tracked by a bit counter 0..WIDTH-1; transition to DONE after the last count.
REQ-025 DONE: res_valid=1 and res_data=pout, held stable until res_ready=1; on that edge, go to IDLE.
REQ-026 pload and enable SHALL never be 1 in the same cycle and SHALL be 0 outside LOAD and SHIFT.
REQ-027 Latency: for a push at edge E0 into an empty FIFO with the FSM in IDLE, pload is high during E1..E2, enable is high during E2..E(2+WIDTH), and res_valid rises at E(2+WIDTH), i.e. 10 cycles for WIDTH=8.
REQ-028 Throughput: a queued pair SHALL start on the cycle after DONE exits, giving WIDTH+3 cycles per operation with res_ready held at 1.
REQ-029 res_ready held at 0 SHALL stall the FSM in DONE while the FIFO still accepts pushes, up to DEPTH pairs.
REQ-030 res_ready while res_valid=0 SHALL have no effect.

Reset
REQ-031 rst=1 at an edge SHALL force: FSM to IDLE, FIFO empty (in_ready=1), bit counter 0, pload=0, enable=0, adata=bdata=0, res_valid=0, busy=0.
REQ-032 rst SHALL take priority over all other inputs, including mid-SHIFT and in DONE; any in-flight and queued pairs are discarded.

Structure
REQ-033 The FSM state enum and the default WIDTH/DEPTH constants SHALL live in the shared package serial_add_pkg.
REQ-034 The operand FIFO SHALL be one sub-module, op_fifo, parameterised by WIDTH (stores 2*WIDTH bits) and DEPTH; the FSM and counter stay in serial_add_seq.

Verification
REQ-035 Single op: push A=8'd1, B=8'd2 with res_ready=1 -> one pload pulse, 8 enable cycles, res_valid at +10 cycles with res_data=8'h03, held 1 cycle.
REQ-036 Wrap: A=8'hFF, B=8'h01 -> res_data=8'h00; A=8'hF0, B=8'h0F -> 8'hFF.
REQ-037 Back-pressure: push 3 pairs (2+3, 4+5, 6+7) with res_ready=0 -> in_ready=0 after 2 pairs are queued; release res_ready -> results 05, 09, 0D in order, 11 cycles apart.
REQ-038 Simultaneous push/pop: push on the IDLE->LOAD edge -> occupancy unchanged, no lost or duplicated pair.
REQ-039 Reset mid-SHIFT: assert rst after the 4th enable of 8'h10+8'h20 -> next cycle pload=enable=res_valid=0, in_ready=1; a fresh 8'h02+8'h03 then yields 8'h05.
REQ-040 Protocol checks, run throughout: pload&enable never both 1; enable high runs are exactly WIDTH cycles; res_data stable while res_valid & !res_ready.
